// File: rtl/dmem_ctrl.sv
// dmem_ctrl
// Sequencing and arbitration controller in front of a single-port data memory.
// A CPU load/store port and a debug/loader port share the memory under
// round-robin arbitration. Sub-word CPU stores become a read-modify-write of
// the whole word, and sub-word CPU loads are returned sign- or zero-extended.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   cpu_*           CPU request/response (byte address, size, sign-extend)
//   dbg_*           debug request/response (word address, word access only)
//   dm_*            memory port (read/write enables, word address, data)
module dmem_ctrl #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_size,
    input  logic              cpu_sext,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [31:0]       cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_ack,
    output logic [31:0]       dbg_rdata,
    output logic              dm_r,
    output logic              dm_w,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    state_t            state_q, state_d;
    logic              last_dbg_q, last_dbg_d;
    logic              gnt_dbg_q, gnt_dbg_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [31:0]       merge_q, merge_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic [31:0]       dbg_rdata_q, dbg_rdata_d;

    logic              cpu_misaligned;
    logic              is_sub;
    logic [15:0]       half_lane;
    logic [7:0]        byte_lane;
    logic [31:0]       load_ext;
    logic [31:0]       merged;
    logic              dm_r_c, dm_w_c, cpu_ack_c, cpu_err_c, dbg_ack_c;
    logic [ADDR_W-1:0] dm_addr_c;
    logic [31:0]       dm_wdata_c;

    // Address bits above the memory's reach are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[31:ADDR_W+2];

    // Size 11 behaves as a word access, so only 01 and 10 are sub-word.
    assign cpu_misaligned = ((cpu_size == 2'b01) && cpu_addr[0]) ||
                            (((cpu_size == 2'b00) || (cpu_size == 2'b11)) && (cpu_addr[1:0] != 2'b00));
    assign is_sub = (size_q == 2'b01) || (size_q == 2'b10);

    // Extract and extend the addressed lane of the word coming back from memory.
    always_comb begin
        half_lane = lane_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        byte_lane = dm_rdata[{lane_q, 3'b000} +: 8];
        load_ext  = dm_rdata;
        if (size_q == 2'b01) begin
            load_ext = {{16{sext_q & half_lane[15]}}, half_lane};
        end else if (size_q == 2'b10) begin
            load_ext = {{24{sext_q & byte_lane[7]}}, byte_lane};
        end
    end

    // Replace the target lane of the captured word with the store data.
    always_comb begin
        merged = merge_q;
        if (size_q == 2'b01) begin
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end else if (size_q == 2'b10) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        last_dbg_d  = last_dbg_q;
        gnt_dbg_d   = gnt_dbg_q;
        we_d        = we_q;
        size_d      = size_q;
        sext_d      = sext_q;
        addr_d      = addr_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        merge_d     = merge_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        dm_r_c      = 1'b0;
        dm_w_c      = 1'b0;
        dm_addr_c   = '0;
        dm_wdata_c  = '0;
        cpu_ack_c   = 1'b0;
        cpu_err_c   = 1'b0;
        dbg_ack_c   = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the requester that was not granted last time wins.
                if (cpu_req && (!dbg_req || last_dbg_q)) begin
                    gnt_dbg_d  = 1'b0;
                    last_dbg_d = 1'b0;
                    we_d       = cpu_we;
                    size_d     = cpu_size;
                    sext_d     = cpu_sext;
                    addr_d     = cpu_addr[ADDR_W+1:2];
                    lane_d     = cpu_addr[1:0];
                    wdata_d    = cpu_wdata;
                    err_d      = cpu_misaligned;
                    state_d    = cpu_misaligned ? RESP : ACCESS;
                end else if (dbg_req) begin
                    gnt_dbg_d  = 1'b1;
                    last_dbg_d = 1'b1;
                    we_d       = dbg_we;
                    size_d     = 2'b00;
                    sext_d     = 1'b0;
                    addr_d     = dbg_addr;
                    lane_d     = 2'b00;
                    wdata_d    = dbg_wdata;
                    err_d      = 1'b0;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                dm_addr_c = addr_q;
                if (!we_q) begin
                    dm_r_c = 1'b1;
                    if (gnt_dbg_q) begin
                        dbg_rdata_d = load_ext;
                    end else begin
                        cpu_rdata_d = load_ext;
                    end
                    state_d = RESP;
                end else if (is_sub) begin
                    dm_r_c  = 1'b1;
                    merge_d = dm_rdata;
                    state_d = MERGE;
                end else begin
                    dm_w_c     = 1'b1;
                    dm_wdata_c = wdata_q;
                    state_d    = RESP;
                end
            end
            MERGE: begin
                dm_addr_c  = addr_q;
                dm_w_c     = 1'b1;
                dm_wdata_c = merged;
                state_d    = RESP;
            end
            RESP: begin
                cpu_ack_c = ~gnt_dbg_q;
                cpu_err_c = ~gnt_dbg_q & err_q;
                dbg_ack_c = gnt_dbg_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are suppressed during reset so an abandoned store never commits.
    assign dm_r      = dm_r_c & ~rst;
    assign dm_w      = dm_w_c & ~rst;
    assign dm_addr   = dm_addr_c;
    assign dm_wdata  = dm_wdata_c;
    assign cpu_ack   = cpu_ack_c & ~rst;
    assign cpu_err   = cpu_err_c & ~rst;
    assign dbg_ack   = dbg_ack_c & ~rst;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_dbg_q  <= 1'b1;
            gnt_dbg_q   <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            sext_q      <= 1'b0;
            addr_q      <= '0;
            lane_q      <= 2'b00;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            merge_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_dbg_q  <= last_dbg_d;
            gnt_dbg_q   <= gnt_dbg_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sext_q      <= sext_d;
            addr_q      <= addr_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            merge_q     <= merge_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl
// Directed bench for dmem_ctrl with a behavioural memory behind it. Expected
// responses are pushed per requester when a request is driven and popped when
// the matching ack appears.
module tb_dmem_ctrl;

    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req, cpu_we, cpu_sext;
    logic [1:0]        cpu_size;
    logic [31:0]       cpu_addr, cpu_wdata;
    logic              cpu_ack, cpu_err;
    logic [31:0]       cpu_rdata;
    logic              dbg_req, dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_ack;
    logic [31:0]       dbg_rdata;
    logic              dm_r, dm_w;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata, dm_rdata;

    typedef struct {
        bit          checkData;
        logic [31:0] rdata;
        bit          err;
        int          lat;
        int          start;
    } exp_t;

    exp_t        cpuExpQ[$];
    exp_t        dbgExpQ[$];
    logic [31:0] mem    [0:(1<<ADDR_W)-1];
    logic [31:0] refMem [0:(1<<ADDR_W)-1];
    int          cyc = 0;
    int          nChecks = 0;
    int          nFail = 0;
    int          cpuAckCyc, dbgAckCyc;
    int          dmActive = 0;
    int          bothViol = 0;
    logic [31:0] lastDmAddr = 32'h0;

    dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_sext(cpu_sext),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .dm_r(dm_r), .dm_w(dm_w), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    // Free-running clock and a cycle counter used to measure ack latency.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port memory: write on the edge, combinational read.
    always @(posedge clk) if (dm_w) mem[dm_addr] <= dm_wdata;
    assign dm_rdata = dm_r ? mem[dm_addr] : 32'h0;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_cpu_ack"},   {31'h0, cpu_ack}, 32'h0);
        checkOutput({tag, "_cpu_err"},   {31'h0, cpu_err}, 32'h0);
        checkOutput({tag, "_dbg_ack"},   {31'h0, dbg_ack}, 32'h0);
        checkOutput({tag, "_dm_r"},      {31'h0, dm_r}, 32'h0);
        checkOutput({tag, "_dm_w"},      {31'h0, dm_w}, 32'h0);
        checkOutput({tag, "_dm_addr"},   {21'h0, dm_addr}, 32'h0);
        checkOutput({tag, "_dm_wdata"},  dm_wdata, 32'h0);
        checkOutput({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
        checkOutput({tag, "_dbg_rdata"}, dbg_rdata, 32'h0);
    endtask

    // Drive one request and push its expected response computed from the
    // reference memory; lat < 0 means the latency is not checked (it waits).
    task automatic applyStimulus(input bit isDbg, input bit we, input logic [1:0] size,
                                 input bit sext, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int lat);
        exp_t              e;
        logic [ADDR_W-1:0] idx;
        logic [31:0]       mask, old, val;
        int                sft;
        bit                mis;
        e.start = cyc;
        e.lat = lat;
        e.err = 1'b0;
        e.checkData = !we;
        e.rdata = 32'h0;
        if (isDbg) begin
            idx = addr[ADDR_W-1:0];
            if (we) refMem[idx] = wdata;
            else    e.rdata = refMem[idx];
            dbg_we = we; dbg_addr = idx; dbg_wdata = wdata; dbg_req = 1'b1;
            dbgExpQ.push_back(e);
        end else begin
            idx = addr[ADDR_W+1:2];
            mis = (size == 2'b01) ? addr[0] : (size == 2'b10) ? 1'b0 : (addr[1:0] != 2'b00);
            if (mis) begin
                e.err = 1'b1;
                e.checkData = 1'b0;
            end else begin
                old = refMem[idx];
                if (size == 2'b01) begin
                    sft = addr[1] ? 16 : 0;
                    mask = 32'h0000FFFF << sft;
                end else if (size == 2'b10) begin
                    sft = 8 * int'(addr[1:0]);
                    mask = 32'h000000FF << sft;
                end else begin
                    sft = 0;
                    mask = 32'hFFFFFFFF;
                end
                if (we) begin
                    refMem[idx] = (old & ~mask) | ((wdata << sft) & mask);
                end else begin
                    val = (old & mask) >> sft;
                    if (sext && size == 2'b01 && val[15]) val = val | 32'hFFFF0000;
                    if (sext && size == 2'b10 && val[7])  val = val | 32'hFFFFFF00;
                    e.rdata = val;
                end
            end
            cpu_we = we; cpu_size = size; cpu_sext = sext; cpu_addr = addr;
            cpu_wdata = wdata; cpu_req = 1'b1;
            cpuExpQ.push_back(e);
        end
    endtask

    // Watch both ack lines until every queued expectation has been matched,
    // dropping each req in the cycle after its ack.
    task automatic runUntilIdle(input int budget);
        exp_t e;
        bit   cpuSeen, dbgSeen;
        int   n = 0;
        while ((cpuExpQ.size() != 0 || dbgExpQ.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
            if (dm_r && dm_w) bothViol++;
            if (dm_r || dm_w) begin
                dmActive++;
                lastDmAddr = {21'h0, dm_addr};
            end
            cpuSeen = cpu_ack;
            dbgSeen = dbg_ack;
            if (cpuSeen) begin
                checkOutput("cpu_ack_expected", cpuExpQ.size(), (cpuExpQ.size() != 0) ? cpuExpQ.size() : 1);
                if (cpuExpQ.size() != 0) begin
                    e = cpuExpQ.pop_front();
                    cpuAckCyc = cyc;
                    checkOutput("cpu_err", {31'h0, cpu_err}, {31'h0, e.err});
                    if (e.checkData) checkOutput("cpu_rdata", cpu_rdata, e.rdata);
                    if (e.lat >= 0)  checkOutput("cpu_latency", cyc - e.start, e.lat);
                end
            end
            if (dbgSeen) begin
                checkOutput("dbg_ack_expected", dbgExpQ.size(), (dbgExpQ.size() != 0) ? dbgExpQ.size() : 1);
                if (dbgExpQ.size() != 0) begin
                    e = dbgExpQ.pop_front();
                    dbgAckCyc = cyc;
                    if (e.checkData) checkOutput("dbg_rdata", dbg_rdata, e.rdata);
                    if (e.lat >= 0)  checkOutput("dbg_latency", cyc - e.start, e.lat);
                end
            end
            @(posedge clk);
            #1;
            if (cpuSeen) cpu_req = 1'b0;
            if (dbgSeen) dbg_req = 1'b0;
        end
        if (cpuExpQ.size() != 0 || dbgExpQ.size() != 0) begin
            checkOutput("ack_timeout", cpuExpQ.size() + dbgExpQ.size(), 0);
            cpuExpQ.delete();
            dbgExpQ.delete();
            cpu_req = 1'b0;
            dbg_req = 1'b0;
        end
    endtask

    // Directed sequence: reset, arbitration, stores/loads, misalignment, reset abort.
    initial begin
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_sext = 1'b0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = 32'h0;
        cpuAckCyc = 0; dbgAckCyc = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) refMem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1;

        $display("[TB] tie from reset: CPU then debug");
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h40, 32'hCAFEF00D, 2);
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 32'd17, 32'h0BADF00D, -1);
        runUntilIdle(20);
        checkOutput("tie1_cpu_first", {31'h0, cpuAckCyc < dbgAckCyc}, 32'h1);

        // A lone CPU access leaves last_grant on the CPU, so the next tie goes to debug.
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 2);
        runUntilIdle(20);
        $display("[TB] tie after CPU grant: debug then CPU");
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h44, 32'h0, -1);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'd16, 32'h0, 2);
        runUntilIdle(20);
        checkOutput("tie2_dbg_first", {31'h0, dbgAckCyc < cpuAckCyc}, 32'h1);

        $display("[TB] word store and load");
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF, 2);
        runUntilIdle(20);
        checkOutput("store_dm_addr", lastDmAddr, 32'd4);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 2);
        runUntilIdle(20);
        checkOutput("word_load_value", cpu_rdata, 32'hDEADBEEF);

        $display("[TB] byte store read-modify-write and extended byte loads");
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 32'd4, 32'h11223344, 2);
        runUntilIdle(20);
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h000000AA, 3);
        runUntilIdle(20);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'd4, 32'h0, 2);
        runUntilIdle(20);
        checkOutput("byte_merged_word", dbg_rdata, 32'h11AA3344);
        applyStimulus(1'b0, 1'b0, 2'b10, 1'b1, 32'h12, 32'h0, 2);
        runUntilIdle(20);
        checkOutput("byte_load_sext", cpu_rdata, 32'hFFFFFFAA);
        applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 2);
        runUntilIdle(20);
        checkOutput("byte_load_zext", cpu_rdata, 32'h000000AA);

        $display("[TB] half store, half load, misaligned half");
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 32'd5, 32'h00000000, 2);
        runUntilIdle(20);
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h16, 32'h0000BEEF, 3);
        runUntilIdle(20);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'd5, 32'h0, 2);
        runUntilIdle(20);
        checkOutput("half_merged_word", dbg_rdata, 32'hBEEF0000);
        applyStimulus(1'b0, 1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 2);
        runUntilIdle(20);
        dmActive = 0;
        applyStimulus(1'b0, 1'b0, 2'b01, 1'b0, 32'h15, 32'h0, 1);
        runUntilIdle(20);
        checkOutput("misaligned_no_mem", dmActive, 0);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h1E, 32'h12345678, 1);
        runUntilIdle(20);

        $display("[TB] reset during MERGE");
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 32'd8, 32'h01020304, 2);
        runUntilIdle(20);
        cpu_we = 1'b1; cpu_size = 2'b10; cpu_sext = 1'b0; cpu_addr = 32'h20;
        cpu_wdata = 32'h00000055; cpu_req = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rmw_access_read", {31'h0, dm_r}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_merge_dm_w", {31'h0, dm_w}, 32'h0);
        checkOutput("rst_merge_ack", {31'h0, cpu_ack}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        checkAllZero("post_rst");
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'd8, 32'h0, 2);
        runUntilIdle(20);
        checkOutput("rst_word_kept", dbg_rdata, 32'h01020304);

        $display("[TB] debug store then CPU load");
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 32'd7, 32'h12345678, 2);
        runUntilIdle(20);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h1C, 32'h0, 2);
        runUntilIdle(20);
        checkOutput("dbg_to_cpu_value", cpu_rdata, 32'h12345678);

        checkOutput("dm_r_w_exclusive", bothViol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
